// File: rtl/mod_count_pkg.sv
// rtl/mod_count_pkg.sv - shared FSM state type and modulus limit for the modulo-count scheduler
package mod_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned MIN_MOD = 2;

endpackage

// File: rtl/mod_count_sched_rr_arbiter.sv
// rtl/mod_count_sched_rr_arbiter.sv - combinational round-robin arbiter, priority starts at ptr
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant
);

    int  idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_count_sched.sv
// rtl/mod_count_sched.sv - round-robin scheduler running a shared modulo counter per grant
// Optional abort input enabled by MOD_COUNT_SCHED_ABORT_EN.
module mod_count_sched
    import mod_count_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
`ifdef MOD_COUNT_SCHED_ABORT_EN
    input  logic                     abort,
`endif
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   mod_in,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic [WIDTH-1:0]         cnt,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic                     err
);

    localparam int IDW = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic [IDW-1:0]   arb_next;
    logic [WIDTH-1:0] arb_mod;
    logic             arb_legal;
    logic             abort_w;

`ifdef MOD_COUNT_SCHED_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_gnt)
    );

    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                arb_idx = IDW'(i);
            end
        end
        arb_mod   = mod_in[arb_idx*WIDTH +: WIDTH];
        arb_legal = 32'(arb_mod) >= MIN_MOD;
        // Explicit wrap keeps the pointer legal when N_REQ is not a power of two.
        arb_next  = (arb_idx == IDW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        mod_d   = mod_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    ptr_d = arb_next;
                    id_d  = arb_idx;
                    mod_d = arb_mod;
                    cnt_d = '0;
                    if (arb_legal) begin
                        gnt_d   = arb_gnt;
                        state_d = ST_RUN;
                    end else begin
                        gnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (abort_w) begin
                    cnt_d   = '0;
                    gnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == mod_q - WIDTH'(1)) begin
                    cnt_d   = '0;
                    gnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            mod_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            mod_q   <= mod_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            err_q   <= err_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q == ST_RUN);
    assign cnt     = cnt_q;
    assign done    = (state_q == ST_DONE);
    assign done_id = (state_q == ST_DONE) ? id_q : '0;
    assign err     = err_q;

endmodule

// File: tb/tb_mod_count_sched.sv
// tb/tb_mod_count_sched.sv - directed self-checking bench for mod_count_sched
module tb_mod_count_sched;

    logic        clk;
    logic        rstn;
    logic        abort;
    logic [3:0]  req;
    logic [15:0] mod_in;
    logic [3:0]  gnt;
    logic        busy;
    logic [3:0]  cnt;
    logic        done;
    logic [1:0]  done_id;
    logic        err;

    int checks;
    int failures;

    mod_count_sched #(.N_REQ(4), .WIDTH(4)) dut (
        .clk     (clk),
        .rstn    (rstn),
`ifdef MOD_COUNT_SCHED_ABORT_EN
        .abort   (abort),
`endif
        .req     (req),
        .mod_in  (mod_in),
        .gnt     (gnt),
        .busy    (busy),
        .cnt     (cnt),
        .done    (done),
        .done_id (done_id),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cnt"}, 32'(cnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_done_id"}, 32'(done_id), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        req    = '0;
        mod_in = '0;
        abort  = 1'b0;
        #1;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        int grants_seen;
        int expect_idx;
        logic [3:0] prev_gnt;

        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        req      = '0;
        mod_in   = '0;
        abort    = 1'b0;
        #2;
        chk_all_zero("reset");
        step();
        rstn = 1'b1;

        // Single requester, modulus 3
        do_reset();
        req    = 4'b0001;
        mod_in = 16'h0003;
        step();
        chk("m3_gnt", 32'(gnt), 32'h1);
        chk("m3_busy", 32'(busy), 32'd1);
        chk("m3_cnt0", 32'(cnt), 32'd0);
        req    = 4'b0000;
        mod_in = 16'h000F;
        step();
        chk("m3_cnt1", 32'(cnt), 32'd1);
        step();
        chk("m3_cnt2", 32'(cnt), 32'd2);
        chk("m3_not_done_yet", 32'(done), 32'd0);
        step();
        chk("m3_done", 32'(done), 32'd1);
        chk("m3_done_id", 32'(done_id), 32'd0);
        chk("m3_err", 32'(err), 32'd0);
        chk("m3_gnt_off", 32'(gnt), 32'd0);
        chk("m3_busy_off", 32'(busy), 32'd0);
        chk("m3_cnt_clr", 32'(cnt), 32'd0);
        step();
        chk("m3_done_pulse", 32'(done), 32'd0);
        step();
        chk("m3_no_regrant", 32'(gnt), 32'd0);

        // Round-robin among all four, modulus 2 each
        do_reset();
        mod_in      = 16'h2222;
        req         = 4'b1111;
        grants_seen = 0;
        prev_gnt    = '0;
        for (int c = 0; c < 40 && grants_seen < 5; c++) begin
            step();
            chk("rr_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                expect_idx = grants_seen % 4;
                chk("rr_order", 32'(gnt), 32'(4'b0001 << expect_idx));
                grants_seen++;
            end
            prev_gnt = gnt;
        end
        chk("rr_grant_count", 32'(grants_seen), 32'd5);
        req = '0;

        // Illegal moduli 0 and 1 on requester 1
        do_reset();
        req    = 4'b0010;
        mod_in = 16'h0000;
        step();
        chk("m0_done", 32'(done), 32'd1);
        chk("m0_err", 32'(err), 32'd1);
        chk("m0_done_id", 32'(done_id), 32'd1);
        chk("m0_busy", 32'(busy), 32'd0);
        chk("m0_gnt", 32'(gnt), 32'd0);
        chk("m0_cnt", 32'(cnt), 32'd0);
        req = 4'b0000;
        step();
        chk("m0_err_pulse", 32'(err), 32'd0);
        req    = 4'b0010;
        mod_in = 16'h0010;
        step();
        chk("m1_done", 32'(done), 32'd1);
        chk("m1_err", 32'(err), 32'd1);
        chk("m1_done_id", 32'(done_id), 32'd1);
        chk("m1_cnt", 32'(cnt), 32'd0);
        req = 4'b0000;
        step();

        // Reset on third RUN cycle, then pointer must restart at index 0
        do_reset();
        req    = 4'b0100;
        mod_in = 16'h0700;
        step();
        chk("mr_gnt", 32'(gnt), 32'h4);
        step();
        step();
        chk("mr_cnt2", 32'(cnt), 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("mr_async");
        step();
        rstn   = 1'b1;
        req    = 4'b1001;
        mod_in = 16'h2702;
        step();
        chk("mr_next_gnt", 32'(gnt), 32'h1);
        req = '0;

        // Largest modulus 15: cnt walks 0..14 and never shows 15
        do_reset();
        req    = 4'b0001;
        mod_in = 16'h000F;
        step();
        chk("m15_cnt0", 32'(cnt), 32'd0);
        req = '0;
        for (int k = 1; k < 15; k++) begin
            step();
            chk("m15_cnt", 32'(cnt), 32'(k));
        end
        step();
        chk("m15_done", 32'(done), 32'd1);
        chk("m15_cnt_clr", 32'(cnt), 32'd0);

`ifdef MOD_COUNT_SCHED_ABORT_EN
        // Abort at cnt=2 with modulus 9
        do_reset();
        req    = 4'b0001;
        mod_in = 16'h0009;
        step();
        req = '0;
        step();
        step();
        chk("ab_cnt2", 32'(cnt), 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_done", 32'(done), 32'd1);
        chk("ab_err", 32'(err), 32'd1);
        chk("ab_cnt", 32'(cnt), 32'd0);
        chk("ab_gnt", 32'(gnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
